// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU types and constants for the pipeline control blocks
package cpu_pkg;
    typedef enum logic {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } state_t;

    localparam int          REG_W     = 4;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - ID/EX hazard inputs and pipeline enable/flush outputs
interface pipe_hazard_ctrl_if #(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
);
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_use_rs1;
    logic             id_use_rs2;
    logic             ex_mem_read;
    logic [REG_W-1:0] ex_rd;
    logic             ex_md;
    logic             ex_redirect;
    logic             pc_we;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_bubble;
    logic             exmem_bubble;
    logic             md_busy;
    logic             md_done;
    logic [CNT_W-1:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd, ex_md, ex_redirect,
        input  pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble,
               md_busy, md_done, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_mem_read, ex_rd, ex_md, ex_redirect,
        output pc_we, ifid_we, ifid_flush, idex_we, idex_bubble, exmem_bubble,
               md_busy, md_done, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// rtl/pipe_hazard_ctrl_hazard_detect.sv - combinational load-use comparator
module hazard_detect #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_mem_read,
    input  logic [REG_W-1:0] ex_rd,
    output logic             load_use
);
    // Register 0 is an ordinary register here, so no zero-address exemption.
    assign load_use = ex_mem_read &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/bubble sequencing for the 5-stage pipeline
module pipe_hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int REG_W      = 4,
    parameter int MD_LATENCY = 16,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int CW = (MD_LATENCY > 2) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(MD_LATENCY - 2);

    if (MD_LATENCY < 2) begin : g_bad_latency
        $error("pipe_hazard_ctrl: MD_LATENCY must be at least 2");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] stall_q;
    logic             load_use;

    hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .id_rs1      (hz.id_rs1),
        .id_rs2      (hz.id_rs2),
        .id_use_rs1  (hz.id_use_rs1),
        .id_use_rs2  (hz.id_use_rs2),
        .ex_mem_read (hz.ex_mem_read),
        .ex_rd       (hz.ex_rd),
        .load_use    (load_use)
    );

    always_comb begin
        hz.pc_we        = 1'b1;
        hz.ifid_we      = 1'b1;
        hz.ifid_flush   = 1'b0;
        hz.idex_we      = 1'b1;
        hz.idex_bubble  = 1'b0;
        hz.exmem_bubble = 1'b0;
        hz.md_busy      = 1'b0;
        hz.md_done      = 1'b0;
        if (!reset) begin
            hz.pc_we        = 1'b0;
            hz.ifid_we      = 1'b0;
            hz.idex_we      = 1'b0;
            hz.ifid_flush   = 1'b1;
            hz.idex_bubble  = 1'b1;
            hz.exmem_bubble = 1'b1;
        end else if (state == MD_WAIT || hz.ex_md) begin
            // EX is frozen on the mul/div until its last cycle; nothing else can intervene.
            hz.md_busy = 1'b1;
            if (state == MD_WAIT && cnt == '0) begin
                hz.md_done = 1'b1;
            end else begin
                hz.pc_we        = 1'b0;
                hz.ifid_we      = 1'b0;
                hz.idex_we      = 1'b0;
                hz.exmem_bubble = 1'b1;
            end
        end else if (hz.ex_redirect) begin
            hz.ifid_flush  = 1'b1;
            hz.idex_bubble = 1'b1;
        end else if (load_use) begin
            hz.pc_we       = 1'b0;
            hz.ifid_we     = 1'b0;
            hz.idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            cnt     <= '0;
            stall_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.ex_md) begin
                        state <= MD_WAIT;
                        cnt   <= CNT_INIT;
                    end
                end
                MD_WAIT: begin
                    if (cnt == '0) state <= RUN;
                    else           cnt   <= cnt - CW'(1);
                end
                default: state <= RUN;
            endcase
            if (!hz.pc_we && stall_q != {CNT_W{1'b1}}) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign hz.stall_cycles = stall_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int MDL   = 4;
    localparam int CW    = 4;
    localparam int SMAX  = (1 << CW) - 1;

    typedef struct {
        logic       rst;
        logic [3:0] rs1, rs2, rd;
        logic       u1, u2, mr, md, rdr;
    } stim_t;

    typedef struct {
        int         cyc;
        logic [7:0] ctrl;
        int         stalls;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.REG_W(4), .CNT_W(CW)) hif ();

    pipe_hazard_ctrl #(.REG_W(4), .MD_LATENCY(MDL), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hif)
    );

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cycle  = 0;
    int   md_left = 0;   // EX cycles still owed to an in-flight mul/div
    int   stalls  = 0;

    // ctrl order: pc_we ifid_we idex_we ifid_flush idex_bubble exmem_bubble md_busy md_done
    function automatic logic [7:0] predict(input stim_t s);
        logic hazard;
        logic [7:0] c;
        hazard = s.mr && ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        if (!s.rst) begin
            md_left = 0;
            stalls  = 0;
            return 8'b000_111_00;
        end
        if (md_left > 0) begin
            c = (md_left == 1) ? 8'b111_000_11 : 8'b000_001_10;
            md_left--;
        end else if (s.md) begin
            c = 8'b000_001_10;
            md_left = MDL - 1;
        end else if (s.rdr) begin
            c = 8'b111_110_00;
        end else if (hazard) begin
            c = 8'b001_010_00;
        end else begin
            c = 8'b111_000_00;
        end
        if (!c[7] && stalls < SMAX) stalls++;
        return c;
    endfunction

    task automatic drive(input stim_t s);
        exp_t e;
        @(posedge clk);
        #1;
        reset           = s.rst;
        hif.id_rs1      = s.rs1;
        hif.id_rs2      = s.rs2;
        hif.id_use_rs1  = s.u1;
        hif.id_use_rs2  = s.u2;
        hif.ex_mem_read = s.mr;
        hif.ex_rd       = s.rd;
        hif.ex_md       = s.md;
        hif.ex_redirect = s.rdr;
        cycle++;
        e.cyc    = cycle;
        e.stalls = s.rst ? stalls : 0;
        e.ctrl   = predict(s);
        sb.push_back(e);
    endtask

    function automatic stim_t quiet(input logic rst);
        stim_t s;
        s.rst = rst; s.rs1 = 4'd1; s.rs2 = 4'd2; s.rd = 4'd3;
        s.u1 = 1'b0; s.u2 = 1'b0; s.mr = 1'b0; s.md = 1'b0; s.rdr = 1'b0;
        return s;
    endfunction

    function automatic stim_t rnd(input logic rst);
        stim_t s;
        s.rst = rst;
        s.rs1 = 4'($urandom_range(0, 3));
        s.rs2 = 4'($urandom_range(0, 3));
        s.rd  = 4'($urandom_range(0, 3));
        s.u1  = 1'($urandom);
        s.u2  = 1'($urandom);
        s.mr  = 1'($urandom);
        s.md  = ($urandom_range(0, 7) == 0);
        s.rdr = ($urandom_range(0, 3) == 0);
        return s;
    endfunction

    function automatic stim_t load_use();
        stim_t s;
        s = quiet(1'b1);
        s.mr = 1'b1; s.rd = 4'd3; s.rs2 = 4'd3; s.u2 = 1'b1; s.rs1 = 4'd5;
        return s;
    endfunction

    // Monitor: outputs are valid every cycle, sampled mid-cycle.
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                got = {hif.pc_we, hif.ifid_we, hif.idex_we, hif.ifid_flush,
                       hif.idex_bubble, hif.exmem_bubble, hif.md_busy, hif.md_done};
                checks++;
                if (got === e.ctrl) passed++;
                else $display("FAIL ctrl cycle %0d: got %b required %b", e.cyc, got, e.ctrl);
                checks++;
                if (int'(hif.stall_cycles) == e.stalls) passed++;
                else $display("FAIL stall_cycles cycle %0d: got %0d required %0d",
                              e.cyc, hif.stall_cycles, e.stalls);
            end
        end
    end

    initial begin
        stim_t s;
        int    budget;
        hif.id_rs1 = '0; hif.id_rs2 = '0; hif.id_use_rs1 = 1'b0; hif.id_use_rs2 = 1'b0;
        hif.ex_mem_read = 1'b0; hif.ex_rd = '0; hif.ex_md = 1'b0; hif.ex_redirect = 1'b0;

        repeat (3) drive(rnd(1'b0));
        repeat (2) drive(quiet(1'b1));

        drive(load_use());
        drive(quiet(1'b1));

        s = load_use(); s.rdr = 1'b1;
        drive(s);
        drive(quiet(1'b1));

        s = quiet(1'b1); s.md = 1'b1;
        repeat (MDL) drive(s);
        repeat (2) drive(quiet(1'b1));

        // Reset lands on the second MD_WAIT cycle; the op must be abandoned.
        repeat (2) drive(s);
        drive(quiet(1'b0));
        repeat (4) drive(quiet(1'b1));

        repeat (20) drive(load_use());
        drive(quiet(1'b1));

        for (int i = 0; i < 400; i++) drive(rnd($urandom_range(0, 39) != 0));

        budget = 10;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        @(posedge clk);
        if (sb.size() > 0) begin
            checks++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
